// File: rtl/spi_burst_pkg.sv
// Shared types and default configuration for the SPI burst master.
package spi_burst_pkg;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_DIV        = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_burst_fifo.sv
// TX FIFO holding {dc, data} entries, with occupancy and full/empty flags.
// Pushes while full are dropped even if a pop happens in the same cycle;
// pops only take entries already stored (no write-through bypass).
module spi_burst_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: ;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_burst_master.sv
// SPI mode-0 burst master with D/C line, fed by a small TX FIFO.
// Optional feature macro: SPI_BURST_CS_HOLD_EN keeps cs_n low across
// consecutive words that share the same dc value (no GAP between them).
module spi_burst_master
  import spi_burst_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned DIV        = DEF_DIV
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic                          wr_dc_i,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          sclk_o,
  output logic                          mosi_o,
  output logic                          cs_n_o,
  output logic                          dc_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rest_bits;   // bits still to be shifted out after mosi_o
  logic [DATA_W:0]   head;
  logic              empty;
  logic              pop_c;
  logic              div_zero_c;
  logic              last_bit_c;

  spi_burst_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (wr_en_i),
    .push_data ({wr_dc_i, wr_data_i}),
    .pop       (pop_c),
    .pop_data  (head),
    .level     (level_o),
    .full      (full_o),
    .empty     (empty)
  );

  assign div_zero_c = (div_cnt == '0);
  assign last_bit_c = (bit_cnt == CNT_W'(DATA_W));
  assign busy_o     = (state != ST_IDLE) || !empty;

  // Word-load strobe. GAP loads directly on its last cycle so cs_n stays
  // high for exactly DIV cycles between words.
  always_comb begin
    pop_c = 1'b0;
    unique case (state)
      ST_IDLE: pop_c = !empty;
      ST_GAP:  pop_c = div_zero_c && !empty;
`ifdef SPI_BURST_CS_HOLD_EN
      ST_HIGH: pop_c = div_zero_c && last_bit_c && !empty && (head[DATA_W] == dc_o);
`endif
      default: pop_c = 1'b0;
    endcase
  end

  // FSM, shifter, dividers and registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      rest_bits <= '0;
      sclk_o    <= 1'b0;
      mosi_o    <= 1'b0;
      cs_n_o    <= 1'b1;
      dc_o      <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (pop_c) begin
        state     <= ST_LOW;
        rest_bits <= head[DATA_W-2:0];
        mosi_o    <= head[DATA_W-1];
        dc_o      <= head[DATA_W];
        cs_n_o    <= 1'b0;
        sclk_o    <= 1'b0;
        div_cnt   <= DIV_RELOAD;
        bit_cnt   <= '0;
        if (state == ST_HIGH) done_o <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            cs_n_o <= 1'b1;
            sclk_o <= 1'b0;
            mosi_o <= 1'b0;
          end
          ST_LOW: begin
            if (div_zero_c) begin
              state   <= ST_HIGH;
              sclk_o  <= 1'b1;
              div_cnt <= DIV_RELOAD;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else begin
              div_cnt <= div_cnt - DIV_W'(1);
            end
          end
          ST_HIGH: begin
            if (div_zero_c) begin
              sclk_o  <= 1'b0;
              div_cnt <= DIV_RELOAD;
              if (last_bit_c) begin
                done_o <= 1'b1;
                state  <= ST_GAP;
                cs_n_o <= 1'b1;
                mosi_o <= 1'b0;
              end else begin
                state     <= ST_LOW;
                mosi_o    <= rest_bits[DATA_W-2];
                rest_bits <= {rest_bits[DATA_W-3:0], 1'b0};
              end
            end else begin
              div_cnt <= div_cnt - DIV_W'(1);
            end
          end
          ST_GAP: begin
            if (div_zero_c) state <= ST_IDLE;
            else            div_cnt <= div_cnt - DIV_W'(1);
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_master.sv
// Scoreboard bench for spi_burst_master: stimulus queues expected words,
// a bus monitor reassembles words from sclk/mosi and checks them.
module tb_spi_burst_master;

  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned DV = 2;
  localparam int unsigned LW = $clog2(FD) + 1;
  localparam int unsigned BW = 16;
  localparam int unsigned BV = 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_dc = 1'b0;
  logic          full, busy, done, sclk, mosi, cs_n, dc;
  logic [LW-1:0] level;

  logic          b_wr_en = 1'b0;
  logic [BW-1:0] b_wr_data = '0;
  logic          b_wr_dc = 1'b0;
  logic          b_full, b_busy, b_done, b_sclk, b_mosi, b_cs_n, b_dc;
  logic [LW-1:0] b_level;

  int checks = 0;
  int errors = 0;

  logic [DW:0] exp_q[$];

  always #5 clk = ~clk;

  spi_burst_master #(.DATA_W(DW), .FIFO_DEPTH(FD), .DIV(DV)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .wr_dc_i(wr_dc), .full_o(full), .level_o(level), .busy_o(busy),
    .done_o(done), .sclk_o(sclk), .mosi_o(mosi), .cs_n_o(cs_n), .dc_o(dc)
  );

  spi_burst_master #(.DATA_W(BW), .FIFO_DEPTH(FD), .DIV(BV)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(b_wr_en), .wr_data_i(b_wr_data),
    .wr_dc_i(b_wr_dc), .full_o(b_full), .level_o(b_level), .busy_o(b_busy),
    .done_o(b_done), .sclk_o(b_sclk), .mosi_o(b_mosi), .cs_n_o(b_cs_n), .dc_o(b_dc)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: rebuild words on sclk rising edges, pop the scoreboard on done.
  int          m_nbits = 0, m_low = 0, m_dones = 0;
  logic [DW-1:0] m_word = '0;
  logic        m_dc = 1'b0;
  logic        p_sclk = 1'b0, p_cs = 1'b1, p_dc = 1'b0;
  logic [DW:0] m_exp;

  always @(negedge clk) begin
    if (rst_i) begin
      m_nbits = 0; m_low = 0; m_dones = 0; m_word = '0;
    end else begin
      if (!cs_n && sclk && !p_sclk) begin
        m_word = {m_word[DW-2:0], mosi};
        m_dc   = dc;
        m_nbits++;
      end
      if (!cs_n) m_low++;
      if (!cs_n && !p_cs && dc != p_dc) chk("dc_change_while_cs_low", dc, p_dc);
      if (done) begin
        m_dones++;
        chk("sb_bits", m_nbits, DW);
        if (exp_q.size() == 0) chk("sb_unexpected_word", m_word, 0);
        else begin
          m_exp = exp_q.pop_front();
          chk("sb_data", m_word, m_exp[DW-1:0]);
          chk("sb_dc", m_dc, m_exp[DW]);
        end
        m_nbits = 0;
      end
      if (cs_n && !p_cs) begin
        chk("cs_low_len", m_low, 2 * DW * DV * m_dones);
        m_low = 0; m_dones = 0;
      end
    end
    p_sclk = sclk; p_cs = cs_n; p_dc = dc;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_a(input logic [DW-1:0] d, input logic c, input bit acc);
    wr_en = 1'b1; wr_data = d; wr_dc = c;
    if (acc) exp_q.push_back({c, d});
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) chk("idle_timeout", n, 0);
  endtask

  // Collects cs_n low-run lengths and the first high gap between runs.
  task automatic measure_a(output int nr, output int r0, output int g0, output int r1);
    int cur = 0, hi = 0;
    bit was_low = 0;
    nr = 0; r0 = 0; g0 = 0; r1 = 0;
    repeat (200) begin
      @(negedge clk);
      if (!cs_n) begin
        if (!was_low && nr == 1) g0 = hi;
        cur++; was_low = 1;
      end else begin
        if (was_low) begin
          if (nr == 0) r0 = cur; else if (nr == 1) r1 = cur;
          nr++; cur = 0; hi = 0;
        end
        hi++; was_low = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, r0, g0, r1, dn, k;
    int low, rises, bdone;
    logic [BW-1:0] bw;
    logic first, last, pv;

    tick(3);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1); chk("rst_sclk", sclk, 0); chk("rst_mosi", mosi, 0);
    chk("rst_dc", dc, 0); chk("rst_done", done, 0); chk("rst_full", full, 0);
    chk("rst_busy", busy, 0); chk("rst_level", level, 0);
    @(posedge clk); #1; rst_i = 1'b0;
    tick(1);

    // Single word 0xA5 with first-transaction latency.
    push_a(8'hA5, 1'b1, 1'b1);
    @(negedge clk); chk("lat_cs_before", cs_n, 1); chk("lat_level", level, 1);
    @(negedge clk); chk("lat_cs_low", cs_n, 0); chk("lat_dc", dc, 1); chk("lat_mosi_msb", mosi, 1);
    @(negedge clk); chk("lat_sclk_low", sclk, 0);
    @(negedge clk); chk("lat_sclk_rise", sclk, 1);
    @(posedge clk); #1;
    wait_idle();

    // Reset during bit 3: word aborted, no done afterwards.
    push_a(8'h3C, 1'b0, 1'b0);
    tick(11);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_cs_n", cs_n, 1); chk("abort_sclk", sclk, 0); chk("abort_level", level, 0);
    chk("abort_done", done, 0); chk("abort_busy", busy, 0);
    @(posedge clk); #1; rst_i = 1'b0;
    dn = 0;
    repeat (40) begin @(negedge clk); dn += int'(done); end
    chk("abort_no_done", dn, 0);
    @(posedge clk); #1;

    // Overflow: 8 consecutive pushes, only FIFO_DEPTH+1 are accepted.
    wait_idle();
    for (int i = 0; i < 8; i++) push_a(DW'($urandom), 1'($urandom), i < int'(FD + 1));
    @(negedge clk);
    chk("ovf_level", level, FD); chk("ovf_full", full, 1); chk("ovf_busy", busy, 1);
    @(posedge clk); #1;
    wait_idle();

    // Same-dc back-to-back pair.
    push_a(8'h11, 1'b0, 1'b1);
    push_a(8'h22, 1'b0, 1'b1);
    measure_a(nr, r0, g0, r1);
`ifdef SPI_BURST_CS_HOLD_EN
    chk("same_dc_runs", nr, 1); chk("same_dc_run0", r0, 2 * 2 * DW * DV);
`else
    chk("same_dc_runs", nr, 2); chk("same_dc_run0", r0, 2 * DW * DV);
    chk("same_dc_gap", g0, DV); chk("same_dc_run1", r1, 2 * DW * DV);
`endif
    wait_idle();

    // Differing-dc pair always separates with a gap.
    push_a(8'h11, 1'b0, 1'b1);
    push_a(8'h22, 1'b1, 1'b1);
    measure_a(nr, r0, g0, r1);
    chk("diff_dc_runs", nr, 2); chk("diff_dc_run0", r0, 2 * DW * DV);
    chk("diff_dc_gap", g0, DV); chk("diff_dc_run1", r1, 2 * DW * DV);
    wait_idle();

    // Random bursts.
    for (int it = 0; it < 12; it++) begin
      wait_idle();
      k = int'($urandom_range(1, FD));
      for (int j = 0; j < k; j++) begin
        push_a(DW'($urandom), 1'($urandom), 1'b1);
        tick(int'($urandom_range(0, 2)));
      end
    end
    wait_idle();

    // 16-bit, DIV=1 instance: word 0x8001.
    b_wr_en = 1'b1; b_wr_data = 16'h8001; b_wr_dc = 1'b1;
    @(posedge clk); #1; b_wr_en = 1'b0;
    low = 0; rises = 0; bdone = 0; bw = '0; first = 1'b0; last = 1'b0; pv = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (!b_cs_n) begin
        low++;
        if (b_sclk && !pv) begin
          bw = {bw[BW-2:0], b_mosi}; rises++;
          if (rises == 1) first = b_mosi;
          last = b_mosi;
        end
      end
      bdone += int'(b_done);
      pv = b_sclk;
    end
    chk("b_cs_low_len", low, 2 * BW * BV); chk("b_sclk_pulses", rises, BW);
    chk("b_word", bw, 16'h8001); chk("b_first_bit", first, 1); chk("b_last_bit", last, 1);
    chk("b_done_count", bdone, 1); chk("b_level", b_level, 0);
    chk("b_busy", b_busy, 0); chk("b_full", b_full, 0); chk("b_dc", b_dc, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_burst_master.md
SPI_BURST_MASTER -- requirements
Module: spi_burst_master

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, bits per SPI word (legal 4..32).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, TX FIFO entries (power of 2, >=2).
REQ-003 SHALL provide parameter DIV, default 2, clk_i cycles per SCLK half-period (>=1).
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 wr_en_i  in  1  push request for wr_data_i/wr_dc_i.
REQ-007 wr_data_i  in  DATA_W  word to transmit, MSB first.
REQ-008 wr_dc_i  in  1  data/command flag travelling with the word (1=data, 0=command).
REQ-009 full_o  out  1  FIFO holds FIFO_DEPTH entries.
REQ-010 level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 busy_o  out  1  high whenever the FSM is not in IDLE or the FIFO is non-empty.
REQ-012 done_o  out  1  one-cycle pulse at the end of each word's last SCLK high phase.
REQ-013 sclk_o, mosi_o, cs_n_o, dc_o  out  1 each  SPI mode-0 bus plus D/C line.

Function
REQ-014 Push SHALL occur when wr_en_i && !full_o; a push while full_o=1 SHALL be dropped with no state change, even if a pop occurs in the same cycle.
REQ-015 Simultaneous push and pop SHALL leave level_o unchanged; a pop SHALL only occur when level_o>0 (no write-through bypass).
REQ-016 FSM states: IDLE, LOW, HIGH, GAP.
REQ-017 IDLE: cs_n_o=1, sclk_o=0; if level_o>0, pop one entry, load the shift register and dc_o, assert cs_n_o=0 with mosi_o=word MSB on the next edge, go LOW.
REQ-018 LOW: sclk_o=0 for DIV cycles, then go HIGH.
REQ-019 HIGH: sclk_o=1 for DIV cycles; at exit, if bits sent < DATA_W, shift so that mosi_o presents the next bit on the falling edge, go LOW.
REQ-020 At HIGH exit after bit DATA_W: pulse done_o for 1 cycle; continuation per REQ-026/027.
REQ-021 GAP: cs_n_o=1, sclk_o=0, mosi_o=0 for DIV cycles, then IDLE.
REQ-022 Latency: a push into an empty FIFO while in IDLE at cycle N SHALL yield cs_n_o=0 at N+2 and the first SCLK rising edge at N+2+DIV.
REQ-023 Word duration (cs_n_o low) SHALL be exactly 2*DATA_W*DIV cycles for an isolated word.
REQ-024 dc_o SHALL remain stable for the whole of cs_n_o low and SHALL only change at a word load.
REQ-025 Bit counter SHALL be $clog2(DATA_W+1) bits wide; the DIV counter SHALL count DIV-1..0 and reload on every phase change.

Configuration
REQ-026 With SPI_BURST_CS_HOLD_EN defined: at the end of a word, if level_o>0 and the next entry's dc equals the current dc_o, pop it, keep cs_n_o=0, and go directly to LOW (back-to-back burst, no GAP).
REQ-027 Without SPI_BURST_CS_HOLD_EN: every word SHALL end via GAP; cs_n_o SHALL deassert for DIV cycles between words.

Reset
REQ-028 On rst_i=1 at a clock edge: FSM=IDLE, FIFO flushed (level_o=0), cs_n_o=1, sclk_o=0, mosi_o=0, dc_o=0, done_o=0, full_o=0, busy_o=0, including mid-word; no done_o is issued for an aborted word.

Structure
REQ-029 Package spi_burst_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-030 The TX FIFO (data+dc, DATA_W+1 bits wide, with level/full) SHALL be the sub-module spi_burst_fifo; the FSM, shifter and dividers SHALL reside in spi_burst_master.

Verification
REQ-031 DATA_W=8, DIV=2, push 0xA5 dc=1 -> mosi_o sampled at 8 SCLK rising edges = 1,0,1,0,0,1,0,1; cs_n_o low 32 cycles; dc_o=1; one done_o.
REQ-032 Hold wr_en_i for 8 cycles while the FSM is stalled mid-word -> level_o saturates at 4, full_o=1, and extra pushes are dropped; exactly 5 words are sent in total.
REQ-033 Push 0x11 dc=0 then 0x22 dc=0 back-to-back -> with CS_HOLD_EN, cs_n_o stays low for 64 cycles; without it, two 32-cycle windows separated by a 2-cycle high gap.
REQ-034 CS_HOLD_EN, push 0x11 dc=0 then 0x22 dc=1 -> cs_n_o rises between the words; dc_o changes only while cs_n_o=1.
REQ-035 Assert rst_i during bit 3 of a word -> next cycle cs_n_o=1, sclk_o=0, level_o=0, and no done_o pulse.
REQ-036 DATA_W=16, DIV=1, push 0x8001 -> 16 SCLK pulses, cs_n_o low 32 cycles, mosi_o first and last bits equal 1.
